// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer: state encoding and
// the opcode values the sequencer needs to recognise.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_CUST  = 7'b0001011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

endpackage

// File: rtl/multicycle_sequencer_opcode_class.sv
// Combinational opcode classifier: tells the sequencer which path
// (WB, MEM load/store, branch) the instruction in IR takes.
module opcode_class
  import seq_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_writes_rd
);

  // Decode the opcode into path classes; unknown opcodes leave legal low.
  always_comb begin
    o_legal     = 1'b0;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    o_writes_rd = 1'b0;
    case (i_opcode)
      OP_R, OP_I, OP_CUST, OP_LUI, OP_JAL, OP_JALR, OP_AUIPC: begin
        o_legal     = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_LW: begin
        o_legal     = 1'b1;
        o_is_load   = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_SW: begin
        o_legal    = 1'b1;
        o_is_store = 1'b1;
      end
      OP_BEQ: begin
        o_legal     = 1'b1;
        o_is_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 datapath. Sequences FETCH/DECODE/
// EXEC/MEM/WB over a single shared memory port and drives the datapath
// write enables. Static decode stays in the combinational control unit.
// Optional: define SEQ_TIMEOUT_EN to build the memory wait timeout that
// raises bus_err and halts; otherwise memory waits are unbounded.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = 32
`ifdef SEQ_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [6:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state, w_next;
  logic             r_stop_pend;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic w_legal, w_is_load, w_is_store, w_is_branch, w_writes_rd;
  logic w_retire, w_set_illegal, w_timeout;

  opcode_class u_cls (
    .i_opcode    (opcode),
    .o_legal     (w_legal),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_writes_rd (w_writes_rd)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err;
  logic              w_waiting;

  // A wait cycle is a FETCH/MEM cycle with no ack; the timeout fires on the
  // MEM_TIMEOUT-th such cycle so the FSM leaves for HALT at that edge.
  assign w_waiting = ((r_state == FETCH) || (r_state == MEM)) && !mem_ack;
  assign w_timeout = w_waiting && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  // Wait counter: restarts on every state entry, counts unacked cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_wait <= '0;
    else if (w_next != r_state)  r_wait <= '0;
    else if (w_waiting)          r_wait <= r_wait + 1'b1;
  end

  // Sticky bus error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_bus_err <= 1'b0;
    else if (w_timeout) r_bus_err <= 1'b1;
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and output decode; ir_we, mdr_we and the MEM-stage pc_we
  // follow mem_ack combinationally so data is captured in the ack cycle.
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel       = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        if (mem_ack)        w_next = DECODE;
        else if (w_timeout) w_next = HALT;
      end
      DECODE: begin
        if (w_legal) begin
          w_next = EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = HALT;
        end
      end
      EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next = MEM;
        end else if (w_is_branch) begin
          pc_we    = 1'b1;
          w_retire = 1'b1;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = w_is_store;
        if (mem_ack) begin
          if (w_is_store) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
          end else begin
            mdr_we = 1'b1;
            w_next = WB;
          end
        end else if (w_timeout) begin
          w_next = HALT;
        end
      end
      WB: begin
        rf_we    = w_writes_rd;
        pc_we    = 1'b1;
        w_retire = 1'b1;
      end
      HALT: ;
      default: w_next = IDLE;
    endcase
    // A stop seen earlier or in the retire cycle itself ends the run here.
    if (w_retire) w_next = (r_stop_pend || stop) ? IDLE : FETCH;
  end

  assign busy = (r_state != IDLE) && (r_state != HALT);

  // Remember a stop request until the current instruction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_stop_pend <= 1'b0;
    else if (w_retire)     r_stop_pend <= 1'b0;
    else if (stop && busy) r_stop_pend <= 1'b1;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 1'b1;
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule
